pipeline_hazard_ctrl: RTL and testbench

//  Central hazard controller for the 5-stage pipeline. Generates operand-forward selects for the

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_forward_sel.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward
// select encoding and the register-match helper used by all compares.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam int REG_AW = 5;

  // A write to x0 is discarded, so index 0 never counts as a dependency.
  function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                   input logic              wren,
                                   input logic [REG_AW-1:0] rs);
    return wren && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Operand forward select for one EX-stage source register.
// MEM data wins over WB data (it is younger); a load still in MEM has no
// data yet, so it is never a MEM forward source.
module forward_sel
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_rd_wren,
  input  logic              i_mem_ld_en,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_rd_wren,
  output fwd_sel_e          o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = reg_hit(i_mem_rd_addr, i_mem_rd_wren, i_rs_addr) && !i_mem_ld_en;
  assign w_wb_hit  = reg_hit(i_wb_rd_addr, i_wb_rd_wren, i_rs_addr);

  // Priority select: youngest producer first.
  always_comb begin
    o_sel = FWD_NONE;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: forward selects,
// per-register advance enables / active-low flushes, load-use bubbles,
// redirect flushes, dmem wait freeze with timeout, saturating perf counters.
//
// Handshake with data memory: a MEM access is in flight while mem_access=1;
// it completes in the cycle dmem_ready=1. Every cycle with mem_access=1 and
// dmem_ready=0 freezes the whole pipeline; nothing else advances until then.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1_addr,
  input  logic [4:0]       ex_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_wren,
  input  logic             ex_ld_en,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_wren,
  input  logic             mem_ld_en,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_wren,
  input  logic             mem_pc_br,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic [1:0]       forwardA_en,
  output logic [1:0]       forwardB_en,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush_n,
  output logic             idex_flush_n,
  output logic             exmem_flush_n,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [TO_W-1:0]  r_wait_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  fwd_sel_e         w_fwd_a;
  fwd_sel_e         w_fwd_b;
  logic             w_wait;
  logic             w_redirect;
  logic             w_load_use;

  forward_sel u_fwd_a (
    .i_rs_addr     (ex_rs1_addr),
    .i_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_wren (mem_rd_wren),
    .i_mem_ld_en   (mem_ld_en),
    .i_wb_rd_addr  (wb_rd_addr),
    .i_wb_rd_wren  (wb_rd_wren),
    .o_sel         (w_fwd_a)
  );

  forward_sel u_fwd_b (
    .i_rs_addr     (ex_rs2_addr),
    .i_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_wren (mem_rd_wren),
    .i_mem_ld_en   (mem_ld_en),
    .i_wb_rd_addr  (wb_rd_addr),
    .i_wb_rd_wren  (wb_rd_wren),
    .o_sel         (w_fwd_b)
  );

  assign forwardA_en = w_fwd_a;
  assign forwardB_en = w_fwd_b;

  assign w_wait     = mem_access && !dmem_ready;
  assign w_redirect = mem_pc_br;
  // Masked in LD_STALL: the bubble already separates the load from its user.
  assign w_load_use = ex_ld_en && (r_state != LD_STALL) &&
                      ((id_rs1_used && reg_hit(ex_rd_addr, ex_rd_wren, id_rs1_addr)) ||
                       (id_rs2_used && reg_hit(ex_rd_addr, ex_rd_wren, id_rs2_addr)));

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state: same priority as the enable decode (wait > redirect > load_use).
  always_comb begin
    w_state_nxt = RUN;
    if (w_wait)                       w_state_nxt = MEM_WAIT;
    else if (!w_redirect && w_load_use) w_state_nxt = LD_STALL;
  end

  // Enable / flush decode (Mealy: follows the inputs in the same cycle).
  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush_n  = 1'b1;
    idex_flush_n  = 1'b1;
    exmem_flush_n = 1'b1;
    if (w_wait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (w_redirect) begin
      ifid_flush_n  = 1'b0;
      idex_flush_n  = 1'b0;
      exmem_flush_n = 1'b0;
    end else if (w_load_use) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush_n = 1'b0;
    end
  end

  // Wait-cycle counter and sticky timeout flag; the error sets on the edge
  // where the count reaches MEM_TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else if (w_wait) begin
      if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + TO_W'(1);
      if (r_wait_cnt == TO_LAST) r_mem_err <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Saturating perf counters: stalled-PC cycles and taken redirects.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_wait && w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err_o   = r_mem_err;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. u_dut uses default parameters;
// u_dut_s shares the same inputs with CNT_W=2 and MEM_TIMEOUT=3 so the
// saturation and timeout corners are reachable in a few cycles.
// Inputs change right after a falling edge; outputs are read 1 ns later.
module tb_pipeline_hazard_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_LD = 2'd1, S_WAIT = 2'd2;

  logic clk_i = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic id_rs1_used, id_rs2_used, ex_rd_wren, ex_ld_en;
  logic mem_rd_wren, mem_ld_en, wb_rd_wren, mem_pc_br, mem_access, dmem_ready;

  logic [1:0]  fwd_a, fwd_b, state, fwd_a_s, fwd_b_s, state_s;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush_n, idex_flush_n, exmem_flush_n, mem_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic        ifid_flush_n_s, idex_flush_n_s, exmem_flush_n_s, mem_err_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;
  logic [4:0]  en_v;
  logic [2:0]  fl_v;

  int errors = 0;
  int checks = 0;

  assign en_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign fl_v = {ifid_flush_n, idex_flush_n, exmem_flush_n};

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl u_dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren), .ex_ld_en(ex_ld_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren), .mem_ld_en(mem_ld_en),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren),
    .mem_pc_br(mem_pc_br), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .forwardA_en(fwd_a), .forwardB_en(fwd_b),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush_n(ifid_flush_n), .idex_flush_n(idex_flush_n), .exmem_flush_n(exmem_flush_n),
    .mem_err_o(mem_err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .state_o(state)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(3), .TO_W(8)) u_dut_s (
    .clk_i(clk_i), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wren(ex_rd_wren), .ex_ld_en(ex_ld_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_wren(mem_rd_wren), .mem_ld_en(mem_ld_en),
    .wb_rd_addr(wb_rd_addr), .wb_rd_wren(wb_rd_wren),
    .mem_pc_br(mem_pc_br), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .forwardA_en(fwd_a_s), .forwardB_en(fwd_b_s),
    .pc_en(pc_en_s), .ifid_en(ifid_en_s), .idex_en(idex_en_s), .exmem_en(exmem_en_s), .memwb_en(memwb_en_s),
    .ifid_flush_n(ifid_flush_n_s), .idex_flush_n(idex_flush_n_s), .exmem_flush_n(exmem_flush_n_s),
    .mem_err_o(mem_err_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s), .state_o(state_s)
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_addr = 5'd0; id_rs2_used = 1'b0;
    ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0;
    ex_rd_addr = 5'd0; ex_rd_wren = 1'b0; ex_ld_en = 1'b0;
    mem_rd_addr = 5'd0; mem_rd_wren = 1'b0; mem_ld_en = 1'b0;
    wb_rd_addr = 5'd0; wb_rd_wren = 1'b0;
    mem_pc_br = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  task automatic drive_load_use();
    ex_rd_addr = 5'd7; ex_rd_wren = 1'b1; ex_ld_en = 1'b1;
    id_rs1_addr = 5'd3; id_rs1_used = 1'b1;
    id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (en_v !== 5'h1F) begin errors++; $display("FAIL reset_en: got %b expected 11111", en_v); end
    checks++; if (fl_v !== 3'b111) begin errors++; $display("FAIL reset_flush: got %b expected 111", fl_v); end
    checks++; if (state !== S_RUN) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", mem_err); end
  endtask

  task automatic test_forward();
    do_reset();
    ex_rs1_addr = 5'd5; ex_rs2_addr = 5'd6;
    mem_rd_addr = 5'd5; mem_rd_wren = 1'b1; wb_rd_addr = 5'd5; wb_rd_wren = 1'b1;
    #1;
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_mem: got %b expected 10", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_b_none: got %b expected 00", fwd_b); end
    mem_rd_wren = 1'b0;
    #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b expected 01", fwd_a); end
    mem_rd_wren = 1'b1; mem_ld_en = 1'b1;
    #1;
    checks++; if (fwd_a === 2'b10 || fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem_load: got %b expected 01", fwd_a); end
    mem_ld_en = 1'b0; ex_rs1_addr = 5'd0; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_x0: got %b expected 00", fwd_a); end
    ex_rs2_addr = 5'd9; mem_rd_addr = 5'd9; wb_rd_addr = 5'd9;
    #1;
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_mem: got %b expected 10", fwd_b); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_load_use();
    #1;
    checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL lu_en: got %b expected 00111", en_v); end
    checks++; if (fl_v !== 3'b101) begin errors++; $display("FAIL lu_flush: got %b expected 101", fl_v); end
    @(negedge clk_i); #1;
    checks++; if (state !== S_LD) begin errors++; $display("FAIL lu_state: got %0d expected 1", state); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    checks++; if (en_v !== 5'h1F || fl_v !== 3'b111) begin errors++;
      $display("FAIL lu_masked: got en=%b fl=%b expected 11111/111", en_v, fl_v); end
    @(negedge clk_i); #1;
    checks++; if (state !== S_RUN) begin errors++; $display("FAIL lu_exit: got %0d expected 0", state); end
    idle_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    drive_load_use();
    mem_pc_br = 1'b1;
    #1;
    checks++; if (en_v !== 5'h1F) begin errors++; $display("FAIL br_en: got %b expected 11111", en_v); end
    checks++; if (fl_v !== 3'b000) begin errors++; $display("FAIL br_flush: got %b expected 000", fl_v); end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin errors++;
      $display("FAIL br_cnt: got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt); end
    checks++; if (state !== S_RUN) begin errors++; $display("FAIL br_state: got %0d expected 0", state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_pc_br = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk_i);
    idle_inputs();
    #1;
    checks++; if (flush_cnt !== 16'd4) begin errors++; $display("FAIL b2b_flush: got %0d expected 4", flush_cnt); end
    checks++; if (flush_cnt_s !== 2'd3) begin errors++; $display("FAIL b2b_flush_sat: got %0d expected 3", flush_cnt_s); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0; mem_pc_br = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (en_v !== 5'h00 || fl_v !== 3'b111) begin errors++;
        $display("FAIL wait_freeze[%0d]: got en=%b fl=%b expected 00000/111", i, en_v, fl_v); end
      if (i > 0) begin
        checks++; if (state !== S_WAIT) begin errors++; $display("FAIL wait_state[%0d]: got %0d expected 2", i, state); end
      end
      @(negedge clk_i);
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (stall_cnt !== 16'd4 || flush_cnt !== 16'd0) begin errors++;
      $display("FAIL wait_cnt: got stall=%0d flush=%0d expected 4/0", stall_cnt, flush_cnt); end
    checks++; if (en_v !== 5'h1F || fl_v !== 3'b000) begin errors++;
      $display("FAIL wait_release: got en=%b fl=%b expected 11111/000", en_v, fl_v); end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++; if (state !== S_RUN || flush_cnt !== 16'd1) begin errors++;
      $display("FAIL wait_resume: got state=%0d flush=%0d expected 0/1", state, flush_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checks++; if (mem_err_s !== (i >= 4)) begin errors++;
        $display("FAIL to_err[%0d]: got %b expected %b", i, mem_err_s, (i >= 4)); end
      @(negedge clk_i);
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (stall_cnt_s !== 2'd3 || stall_cnt !== 16'd5) begin errors++;
      $display("FAIL to_stall: got sat=%0d full=%0d expected 3/5", stall_cnt_s, stall_cnt); end
    @(negedge clk_i);
    idle_inputs();
    #1;
    checks++; if (mem_err_s !== 1'b1 || mem_err !== 1'b0) begin errors++;
      $display("FAIL to_sticky: got small=%b full=%b expected 1/0", mem_err_s, mem_err); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk_i);
    #1;
    checks++; if (state_s !== S_WAIT || mem_err_s !== 1'b1) begin errors++;
      $display("FAIL rmw_pre: got state=%0d err=%b expected 2/1", state_s, mem_err_s); end
    rst_n = 1'b0;
    @(negedge clk_i);
    #1;
    checks++; if (state !== S_RUN || state_s !== S_RUN) begin errors++;
      $display("FAIL rmw_state: got %0d/%0d expected 0/0", state, state_s); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 2'd0 || mem_err_s !== 1'b0) begin errors++;
      $display("FAIL rmw_clear: got stall=%0d/%0d err=%b expected 0/0/0", stall_cnt, stall_cnt_s, mem_err_s); end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
